// File: rtl/scan_rwctr_q.sv
// scan_rwctr_q: queued scan read/write controller with overflow detection, response timeout and sticky error flags
module scan_rwctr_q #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              static_wen,
  input  logic              static_ren,
  input  logic [ADDR_W-1:0] static_addr,
  input  logic [DATA_W-1:0] static_wdata,
  input  logic              err_clr,
  output logic              static_ready,
  output logic [DATA_W-1:0] static_rdata,
  output logic              static_ovf,
  output logic              static_err,
  output logic              scan_wen,
  output logic              scan_ren,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_wdata,
  input  logic [DATA_W-1:0] scan_rdata,
  input  logic              scan_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 1 + ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [TW-1:0] tc_q, tc_d;
  logic wen_q, wen_d, ren_q, ren_d, cur_wr_q, cur_wr_d, ovf_q, ovf_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic acc, full, push, pop, done, tmo;
  logic [EW-1:0] head;
  always_comb begin
    acc = id_valid & (static_wen | static_ren);
    full = cnt_q == (PW+1)'(DEPTH);
    push = acc & ~full;
    pop = state_q == IDLE && cnt_q != '0;
    head = mem_q[rd_q];
    done = state_q != IDLE && scan_ready;
    tmo = state_q == WAIT && !scan_ready && tc_q == TW'(TIMEOUT);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {static_wen, static_addr, static_wdata & {DATA_W{static_wen}}};
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    state_d = state_q == IDLE ? (pop ? ISSUE : IDLE) : (done || tmo) ? IDLE : WAIT;
    tc_d = state_q == ISSUE ? TW'(1) : (state_q == WAIT && !done && !tmo) ? tc_q + TW'(1) : '0;
    wen_d = pop & head[EW-1];
    ren_d = pop & ~head[EW-1];
    addr_d = pop ? head[EW-2:DATA_W] : '0;
    wdata_d = pop ? head[DATA_W-1:0] : '0;
    cur_wr_d = pop ? head[EW-1] : cur_wr_q;
    rdata_d = (done && !cur_wr_q) ? scan_rdata : rdata_q;
    ovf_d = (acc & full) | (ovf_q & ~err_clr);
    err_d = tmo | (err_q & ~err_clr);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      state_q <= IDLE;
      tc_q <= '0;
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cur_wr_q <= 1'b0;
      rdata_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      tc_q <= tc_d;
      wen_q <= wen_d;
      ren_q <= ren_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cur_wr_q <= cur_wr_d;
      rdata_q <= rdata_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  assign static_ready = state_q == IDLE && cnt_q == '0;
  assign static_rdata = rdata_q;
  assign static_ovf = ovf_q;
  assign static_err = err_q;
  assign scan_wen = wen_q;
  assign scan_ren = ren_q;
  assign scan_addr = addr_q;
  assign scan_wdata = wdata_q;
endmodule

// File: tb/tb_scan_rwctr_q.sv
// tb_scan_rwctr_q: directed self-checking bench for scan_rwctr_q
module tb_scan_rwctr_q;
  logic clk = 1'b0;
  logic rst_n, id_valid, static_wen, static_ren, err_clr, scan_ready;
  logic [10:0] static_addr, scan_addr;
  logic [31:0] static_wdata, scan_rdata, static_rdata, scan_wdata;
  logic static_ready, static_ovf, static_err, scan_wen, scan_ren;
  int n_chk = 0, n_err = 0, base;
  logic [10:0] iss [$];
  always #5 clk = ~clk;
  scan_rwctr_q #(.ADDR_W(11), .DATA_W(32), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .static_wen(static_wen), .static_ren(static_ren),
    .static_addr(static_addr), .static_wdata(static_wdata), .err_clr(err_clr),
    .static_ready(static_ready), .static_rdata(static_rdata), .static_ovf(static_ovf), .static_err(static_err),
    .scan_wen(scan_wen), .scan_ren(scan_ren), .scan_addr(scan_addr), .scan_wdata(scan_wdata),
    .scan_rdata(scan_rdata), .scan_ready(scan_ready)
  );
  always @(negedge clk) if (scan_wen | scan_ren) iss.push_back(scan_addr);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic req(input logic w, input logic r, input logic [10:0] a, input logic [31:0] d);
    id_valid = 1'b1;
    static_wen = w;
    static_ren = r;
    static_addr = a;
    static_wdata = d;
    step();
    id_valid = 1'b0;
    static_wen = 1'b0;
    static_ren = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; id_valid = 1'b0; static_wen = 1'b0; static_ren = 1'b0; static_addr = '0;
    static_wdata = '0; err_clr = 1'b0; scan_rdata = '0; scan_ready = 1'b0;
    step(); step();
    chk("rst_ready", static_ready, 1);
    chk("rst_flags", {static_ovf, static_err, scan_wen, scan_ren}, 0);
    chk("rst_data", {static_rdata, scan_addr, scan_wdata}, 0);
    rst_n = 1'b1;
    req(1, 0, 11'h0A5, 32'h12345678);
    chk("wr_busy", static_ready, 0);
    chk("wr_no_early_strobe", scan_wen, 0);
    step();
    chk("wr_strobe", {scan_wen, scan_ren}, 2'b10);
    chk("wr_addr", scan_addr, 11'h0A5);
    chk("wr_wdata", scan_wdata, 32'h12345678);
    step();
    chk("wr_strobe_drop", {scan_wen, scan_addr, scan_wdata}, 0);
    step();
    chk("wr_wait_busy", static_ready, 0);
    scan_ready = 1'b1;
    step();
    scan_ready = 1'b0;
    chk("wr_done_ready", static_ready, 1);
    chk("wr_rdata_kept", static_rdata, 0);
    req(0, 1, 11'h7FF, 32'hFFFFFFFF);
    step();
    chk("rd_strobe", {scan_wen, scan_ren}, 2'b01);
    chk("rd_addr", scan_addr, 11'h7FF);
    chk("rd_wdata_zero", scan_wdata, 0);
    scan_ready = 1'b1;
    scan_rdata = 32'hCAFEF00D;
    step();
    scan_ready = 1'b0;
    chk("rd_rdata", static_rdata, 32'hCAFEF00D);
    chk("rd_idle", {static_ready, scan_ren}, 2'b10);
    base = iss.size();
    for (int i = 0; i < 6; i++) req(0, 1, 11'h100 + 11'(i), 0);
    chk("q_ovf", static_ovf, 1);
    chk("q_err", static_err, 0);
    scan_rdata = 32'h55AA55AA;
    scan_ready = 1'b1;
    for (int i = 0; i < 40 && !static_ready; i++) step();
    scan_ready = 1'b0;
    chk("q_drain", static_ready, 1);
    chk("q_count", iss.size(), base + 5);
    for (int i = 0; i < 5; i++) chk("q_order", iss[base+i], 11'h100 + 11'(i));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", static_ovf, 0);
    req(0, 1, 11'h020, 0);
    req(1, 0, 11'h021, 32'h0000BEEF);
    chk("to_issue", {scan_ren, scan_addr}, {1'b1, 11'h020});
    for (int i = 0; i < 8; i++) step();
    chk("to_not_yet", {static_err, scan_wen}, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("to_err_set_wins", static_err, 1);
    chk("to_rdata_kept", static_rdata, 32'h55AA55AA);
    step();
    chk("to_next_issue", {scan_wen, scan_addr, scan_wdata}, {1'b1, 11'h021, 32'h0000BEEF});
    scan_ready = 1'b1;
    step();
    scan_ready = 1'b0;
    chk("to_next_done", static_ready, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", {static_err, static_ovf}, 0);
    req(0, 1, 11'h030, 0);
    step();
    chk("late_issue", scan_ren, 1);
    scan_rdata = 32'hBEEF0008;
    for (int i = 0; i < 8; i++) step();
    scan_ready = 1'b1;
    step();
    scan_ready = 1'b0;
    chk("late_rdata", static_rdata, 32'hBEEF0008);
    chk("late_no_err", static_err, 0);
    chk("late_ready", static_ready, 1);
    req(1, 1, 11'h040, 32'hA5A5A5A5);
    step();
    chk("both_is_write", {scan_wen, scan_ren}, 2'b10);
    scan_ready = 1'b1;
    step();
    scan_ready = 1'b0;
    base = iss.size();
    id_valid = 1'b0;
    static_wen = 1'b1;
    static_addr = 11'h041;
    for (int i = 0; i < 3; i++) step();
    static_wen = 1'b0;
    chk("novalid_ready", static_ready, 1);
    chk("novalid_no_issue", iss.size(), base);
    req(0, 1, 11'h050, 0);
    req(0, 1, 11'h051, 0);
    req(0, 1, 11'h052, 0);
    step();
    chk("rst_mid_busy", static_ready, 0);
    rst_n = 1'b0;
    step();
    chk("rstm_ready", static_ready, 1);
    chk("rstm_out", {static_rdata, static_ovf, static_err, scan_wen, scan_ren, scan_addr, scan_wdata}, 0);
    rst_n = 1'b1;
    base = iss.size();
    for (int i = 0; i < 5; i++) step();
    chk("rstm_no_issue", iss.size(), base);
    chk("rstm_idle", static_ready, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
